// File: rtl/ans_pkg.sv
// Shared defaults, legal parameter ranges and the valid+sign+word payload
// carried between quantiser stages.
package ans_pkg;

  localparam int TW_DEF   = 32;
  localparam int QW_DEF   = 16;
  localparam int DLY_DEF  = 3;
  localparam int TW_MIN   = 8;
  localparam int TW_MAX   = 64;
  localparam int QW_MIN   = 2;
  localparam int DLY_MIN  = 1;
  localparam int DLY_MAX  = 16;
  localparam int WORD_MAX = TW_MAX - 2;

  typedef struct packed {
    logic                valid;
    logic                sgn;
    logic [WORD_MAX-1:0] word;
  } payload_t;

  function automatic bit params_ok(input int tw, input int qw, input int dly);
    return (tw >= TW_MIN) && (tw <= TW_MAX) &&
           (qw >= QW_MIN) && (qw <= tw - 2) &&
           (dly >= DLY_MIN) && (dly <= DLY_MAX);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Enable-gated shift register of DEPTH stages, W bits wide, cleared by an
// asynchronous active-low reset.
module delay_line #(
  parameter int W     = 18,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] stage_d;
      if (gi == 0) begin : g_head
        assign stage_d = din;
      end else begin : g_tail
        assign stage_d = pipe_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q[gi] <= '0;
        end else if (en) begin
          pipe_q[gi] <= stage_d;
        end
      end
    end
  endgenerate

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/quant_stage.sv
// One quantiser stage: splits A into a QW-bit word (delayed by DLY) and a scaled
// residual target for the next stage. Define QUANT_ROUND_EN for round-to-nearest.
module quant_stage
  import ans_pkg::*;
#(
  parameter int TW  = TW_DEF,
  parameter int QW  = QW_DEF,
  parameter int DLY = DLY_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [TW-1:0] A,
  input  logic          sgn_in,
  output logic [QW-1:0] C,
  output logic          Csgn,
  output logic          c_valid,
  output logic [TW-1:0] nxttgt,
  output logic          nxt_sgn,
  output logic          nxt_valid
);

  localparam int S  = TW - QW;
  localparam int PW = QW + 2;

  generate
    if (!params_ok(TW, QW, DLY)) begin : g_bad_params
      $error("quant_stage: illegal parameters TW=%0d QW=%0d DLY=%0d", TW, QW, DLY);
    end
  endgenerate

  logic [QW-1:0] hi;
  logic [S-1:0]  lo;
  logic [QW-1:0] q_d;
  logic          neg_d;
  logic [S-1:0]  mag_d;

  assign hi = A[TW-1:S];
  assign lo = A[S-1:0];

`ifdef QUANT_ROUND_EN
  logic [QW:0] hi_inc;
  assign hi_inc = {1'b0, hi} + {{QW{1'b0}}, A[S-1]};
  assign q_d    = hi_inc[QW] ? {QW{1'b1}} : hi_inc[QW-1:0];
  // Rounding up leaves r = lo - 2^S; its magnitude is the S-bit two's complement of lo.
  assign neg_d  = A[S-1] & ~hi_inc[QW];
  assign mag_d  = neg_d ? (~lo + {{(S-1){1'b0}}, 1'b1}) : lo;
`else
  assign q_d    = hi;
  assign neg_d  = 1'b0;
  assign mag_d  = lo;
`endif

  logic [TW-1:0] nxttgt_d;
  logic          nxt_sgn_d;
  assign nxttgt_d  = {mag_d, {QW{1'b0}}};
  assign nxt_sgn_d = sgn_in ^ neg_d;

  logic [QW-1:0] q_q;
  logic          sgn_q, vld_q;
  logic [TW-1:0] nxttgt_q;
  logic          nxt_sgn_q, nxt_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      sgn_q     <= 1'b0;
      vld_q     <= 1'b0;
      nxttgt_q  <= '0;
      nxt_sgn_q <= 1'b0;
      nxt_vld_q <= 1'b0;
    end else if (en) begin
      q_q       <= q_d;
      sgn_q     <= sgn_in;
      vld_q     <= in_valid;
      nxttgt_q  <= nxttgt_d;
      nxt_sgn_q <= nxt_sgn_d;
      nxt_vld_q <= in_valid;
    end
  end

  logic [PW-1:0] dl_in, dl_out;
  payload_t      c_pl;

  assign dl_in = {vld_q, sgn_q, q_q};

  delay_line #(.W(PW), .DEPTH(DLY)) u_delay_line (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign c_pl = '{valid: dl_out[PW-1], sgn: dl_out[PW-2], word: WORD_MAX'(dl_out[QW-1:0])};

  assign C         = QW'(c_pl.word);
  assign Csgn      = c_pl.sgn;
  assign c_valid   = c_pl.valid;
  assign nxttgt    = nxttgt_q;
  assign nxt_sgn   = nxt_sgn_q;
  assign nxt_valid = nxt_vld_q;

endmodule
